// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweep engine: drives every input pattern of a small
// combinational block, samples its 1-bit response and tallies mismatches.
module truth_table_sweeper #(
   parameter int                   N_IN   = 3,
   parameter int                   HOLD   = 4,
   parameter bit                   GRAY   = 1'b0,
   parameter logic [(1<<N_IN)-1:0] EXPECT = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail,
   output logic            fail_valid
);

   // state   | meaning
   // S_IDLE  | waiting for start after reset
   // S_DRIVE | sweeping patterns, sampling on the last hold cycle
   // S_DONE  | sweep complete, results and last pattern held

   localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
   localparam logic [N_IN:0]   IDX_LAST  = (N_IN+1)'((1 << N_IN) - 1);
   localparam logic [N_IN:0]   ERR_MAX   = (N_IN+1)'(1 << N_IN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_DONE
   } state_t;

   state_t          state, state_next;
   logic [N_IN:0]   index, index_next;
   logic [HW-1:0]   hold_cnt, hold_next;
   logic [N_IN:0]   err_q, err_next, err_inc;
   logic [N_IN-1:0] ff_q, ff_next;
   logic            fv_q, fv_next;
   logic            pass_q, pass_next;
   logic [N_IN-1:0] pattern;
   logic            sample;
   logic            mismatch;

   // The index stops on the last pattern rather than advancing, so stim
   // naturally holds the final pattern in S_DONE.
   assign pattern  = GRAY ? (index[N_IN-1:0] ^ (index[N_IN-1:0] >> 1))
                          : index[N_IN-1:0];
   assign sample   = (state == S_DRIVE) && (hold_cnt == HOLD_LAST);
   assign mismatch = (dut_out != EXPECT[pattern]);
   assign err_inc  = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         index    <= '0;
         hold_cnt <= '0;
         err_q    <= '0;
         ff_q     <= '0;
         fv_q     <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state    <= state_next;
         index    <= index_next;
         hold_cnt <= hold_next;
         err_q    <= err_next;
         ff_q     <= ff_next;
         fv_q     <= fv_next;
         pass_q   <= pass_next;
      end
   end

   always_comb begin
      state_next = state;
      index_next = index;
      hold_next  = hold_cnt;
      err_next   = err_q;
      ff_next    = ff_q;
      fv_next    = fv_q;
      pass_next  = pass_q;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next = S_DRIVE;
               index_next = '0;
               hold_next  = '0;
               err_next   = '0;
               ff_next    = '0;
               fv_next    = 1'b0;
               pass_next  = 1'b0;
            end
         end
         S_DRIVE: begin
            if (sample) begin
               err_next  = err_inc;
               hold_next = '0;
               if (mismatch && !fv_q) begin
                  ff_next = pattern;
                  fv_next = 1'b1;
               end
               if (index == IDX_LAST) begin
                  state_next = S_DONE;
                  pass_next  = (err_inc == '0);
               end else begin
                  index_next = index + 1'b1;
               end
            end else begin
               hold_next = hold_cnt + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign stim       = pattern;
   assign busy       = (state == S_DRIVE);
   assign done       = (state == S_DONE);
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;
   assign fail_valid = fv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three configurations (binary, Gray, N_IN=4
// HOLD=1) driven by a majority/constant model with injectable output flips.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start_s [3];
   logic dut_out_s [3];
   logic busy_v [3];
   logic done_v [3];
   logic pass_v [3];
   logic fv_v [3];
   int   stim_v [3];
   int   err_v [3];
   int   ff_v [3];

   logic [2:0] stim0, stim1, ff0, ff1;
   logic [3:0] stim2, ff2, err0, err1;
   logic [4:0] err2;

   logic [15:0] flip [3];

   int nin_c  [3] = '{3, 3, 4};
   int hold_c [3] = '{4, 2, 1};
   int gray_c [3] = '{0, 1, 0};

   int checks = 0;
   int errors = 0;

   truth_table_sweeper #(.N_IN(3), .HOLD(4), .GRAY(1'b0), .EXPECT(8'b1110_1000)) u_bin (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .dut_out(dut_out_s[0]),
      .stim(stim0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .err_count(err0), .first_fail(ff0), .fail_valid(fv_v[0]));

   truth_table_sweeper #(.N_IN(3), .HOLD(2), .GRAY(1'b1), .EXPECT(8'b1110_1000)) u_gray (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .dut_out(dut_out_s[1]),
      .stim(stim1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .err_count(err1), .first_fail(ff1), .fail_valid(fv_v[1]));

   truth_table_sweeper #(.N_IN(4), .HOLD(1), .GRAY(1'b0), .EXPECT(16'hFFFF)) u_n4 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .dut_out(dut_out_s[2]),
      .stim(stim2), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .err_count(err2), .first_fail(ff2), .fail_valid(fv_v[2]));

   function automatic logic majority(input int v);
      int ones;
      ones = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
      return (ones >= 2);
   endfunction

   // Truth table the sweeper is configured to expect
   function automatic logic expected_out(input int w, input int v);
      return (w < 2) ? majority(v) : 1'b1;
   endfunction

   // What the simulated block under test actually answers
   function automatic logic resp(input int w, input int v, input logic [15:0] f);
      logic base;
      base = (w < 2) ? majority(v) : 1'b0;
      return base ^ f[v];
   endfunction

   function automatic int pat(input int w, input int k);
      int idx;
      idx = k / hold_c[w];
      return (gray_c[w] != 0) ? (idx ^ (idx >> 1)) : idx;
   endfunction

   always_comb begin
      stim_v[0] = int'(stim0);
      stim_v[1] = int'(stim1);
      stim_v[2] = int'(stim2);
      err_v[0]  = int'(err0);
      err_v[1]  = int'(err1);
      err_v[2]  = int'(err2);
      ff_v[0]   = int'(ff0);
      ff_v[1]   = int'(ff1);
      ff_v[2]   = int'(ff2);
   end

   always_comb begin
      dut_out_s[0] = resp(0, int'(stim0), flip[0]);
      dut_out_s[1] = resp(1, int'(stim1), flip[1]);
      dut_out_s[2] = resp(2, int'(stim2), flip[2]);
   end

   task automatic check_all_zero(input string tag);
      for (int w = 0; w < 3; w++) begin
         checks++;
         if (busy_v[w] !== 1'b0 || done_v[w] !== 1'b0 || pass_v[w] !== 1'b0 ||
             fv_v[w] !== 1'b0 || stim_v[w] != 0 || err_v[w] != 0 || ff_v[w] != 0) begin
            errors++;
            $display("FAIL %s inst%0d: busy=%b done=%b pass=%b fv=%b stim=%0d err=%0d ff=%0d, required all 0",
                     tag, w, busy_v[w], done_v[w], pass_v[w], fv_v[w], stim_v[w], err_v[w], ff_v[w]);
         end
      end
   endtask

   // mode 0: plain sweep, 1: start pulses mid-sweep, 2: reset at cycle 10
   task automatic run_sweep(input int w, input int mode);
      int t, n, v, exp_err, exp_ff;
      logic exp_fv;
      n = 1 << nin_c[w];
      t = n * hold_c[w];
      exp_err = 0;
      exp_ff = 0;
      exp_fv = 1'b0;
      for (int i = 0; i < n; i++) begin
         v = (gray_c[w] != 0) ? (i ^ (i >> 1)) : i;
         if (resp(w, v, flip[w]) != expected_out(w, v)) begin
            exp_err++;
            if (!exp_fv) begin
               exp_ff = v;
               exp_fv = 1'b1;
            end
         end
      end

      @(negedge clk);
      start_s[w] = 1'b1;
      @(negedge clk);
      start_s[w] = 1'b0;
      for (int k = 0; k < t; k++) begin
         checks++;
         if (busy_v[w] !== 1'b1 || done_v[w] !== 1'b0) begin
            errors++;
            $display("FAIL busy_phase inst%0d cyc%0d: busy=%b done=%b, required busy=1 done=0",
                     w, k, busy_v[w], done_v[w]);
         end
         checks++;
         if (stim_v[w] != pat(w, k)) begin
            errors++;
            $display("FAIL stim inst%0d cyc%0d: got %0d, required %0d", w, k, stim_v[w], pat(w, k));
         end
         if (k == 0) begin
            checks++;
            if (err_v[w] != 0 || fv_v[w] !== 1'b0 || pass_v[w] !== 1'b0 || ff_v[w] != 0) begin
               errors++;
               $display("FAIL start_clear inst%0d: err=%0d fv=%b pass=%b ff=%0d, required 0",
                        w, err_v[w], fv_v[w], pass_v[w], ff_v[w]);
            end
         end
         if (mode == 2 && k == 10) begin
            #2 rst_n = 1'b0;
            #1 check_all_zero("async_reset");
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check_all_zero("idle_after_reset");
            return;
         end
         start_s[w] = (mode == 1 && (k == 5 || k == 20));
         @(negedge clk);
      end
      start_s[w] = 1'b0;

      checks++;
      if (busy_v[w] !== 1'b0 || done_v[w] !== 1'b1) begin
         errors++;
         $display("FAIL done_timing inst%0d: busy=%b done=%b after %0d cycles, required busy=0 done=1",
                  w, busy_v[w], done_v[w], t);
      end
      checks++;
      if (err_v[w] != exp_err) begin
         errors++;
         $display("FAIL err_count inst%0d: got %0d, required %0d", w, err_v[w], exp_err);
      end
      checks++;
      if (fv_v[w] !== exp_fv || ff_v[w] != exp_ff) begin
         errors++;
         $display("FAIL first_fail inst%0d: fv=%b ff=%0d, required fv=%b ff=%0d",
                  w, fv_v[w], ff_v[w], exp_fv, exp_ff);
      end
      checks++;
      if (pass_v[w] !== (exp_err == 0)) begin
         errors++;
         $display("FAIL pass inst%0d: got %b, required %b", w, pass_v[w], (exp_err == 0));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done_v[w] !== 1'b1 || busy_v[w] !== 1'b0 || stim_v[w] != pat(w, t - 1) || err_v[w] != exp_err) begin
         errors++;
         $display("FAIL done_hold inst%0d: done=%b busy=%b stim=%0d err=%0d, required done=1 busy=0 stim=%0d err=%0d",
                  w, done_v[w], busy_v[w], stim_v[w], err_v[w], pat(w, t - 1), exp_err);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("idle_no_start");
   endtask

   task automatic test_majority_binary();
      flip[0] = 16'h0000;
      run_sweep(0, 0);
   endtask

   task automatic test_fault_5_6();
      flip[0] = 16'h0060;
      run_sweep(0, 0);
   endtask

   task automatic test_restart_from_done();
      flip[0] = 16'h0000;
      run_sweep(0, 0);
   endtask

   task automatic test_gray();
      flip[1] = 16'h0000;
      run_sweep(1, 0);
      flip[1] = 16'h0044;
      run_sweep(1, 0);
   endtask

   task automatic test_ignore_start();
      flip[0] = 16'h0008;
      run_sweep(0, 1);
   endtask

   task automatic test_reset_mid_sweep();
      flip[0] = 16'h0000;
      run_sweep(0, 2);
      run_sweep(0, 0);
   endtask

   task automatic test_all_fail_n4();
      flip[2] = 16'h0000;
      run_sweep(2, 0);
   endtask

   task automatic test_random();
      int w;
      repeat (8) begin
         w = $urandom_range(0, 2);
         flip[w] = 16'($urandom()) & ((w < 2) ? 16'h00FF : 16'hFFFF);
         run_sweep(w, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0;
         flip[i] = 16'h0000;
      end
      test_reset();
      test_majority_binary();
      test_fault_5_6();
      test_restart_from_done();
      test_gray();
      test_ignore_start();
      test_reset_mid_sweep();
      test_all_fail_n4();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
